mips_control_fsm: RTL and testbench
===================================

# mips_control_fsm

Multicycle control unit for the basic MIPS CPU, directly upstream of the ALU. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath select/enable, including the 4-bit ALUCtl consumed by the ALU. It samples the ALU Zero flag to resolve beq.

## Interface
- No parameters; all encodings are fixed constants in the shared package.
- clk  in  1  single clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state INIT
- Op  in  6  instruction register bits [31:26]
- Funct  in  6  instruction register bits [5:0]
- Zero  in  1  ALU Zero flag (ALUOut == 0)
- ALUCtl  out  4  0=AND, 1=OR, 2=ADD, 6=SUB, 7=SLT
- ALUSrcA  out  1  0=PC, 1=register A
- ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- PCSource  out  2  00=ALU result, 01=ALUOut register, 10=jump target
- PCEn  out  1  PCWrite | (PCWriteCond & Zero)
- IorD  out  1  0=PC addresses memory, 1=ALUOut addresses memory
- MemRead, MemWrite, IRWrite, RegWrite  out  1 each  enables
- RegDst  out  1  0=rt, 1=rd
- MemtoReg  out  1  0=ALUOut, 1=memory data register
- Retire  out  1  high in the final cycle of each legal instruction
- Illegal  out  1  high in DECODE when Op/Funct is unsupported
- State  out  4  current state, for debug

## Operation
- Supported instructions:
  - R-type (Op 0x00) with Funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- Moore outputs are decoded from the state register only. Exceptions: PCEn uses live Zero; Illegal uses live Op/Funct. Any output not listed for a state is 0.
- INIT (0xF): all outputs 0 → FETCH.
- FETCH (0): MemRead, IRWrite, PCWrite; IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtl=2, PCSource=00 → DECODE.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUCtl=2 (branch target precompute). Next state:
  - lw/sw → MEMADR
  - R-type with legal Funct → EXEC
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - otherwise Illegal=1 → FETCH, instruction skipped as a NOP.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUCtl=2 → MEMRD for lw, MEMWR for sw. Op is re-sampled here; IR is stable.
- MEMRD (3): MemRead, IorD=1 → MEMWB.
- MEMWB (4): RegWrite, MemtoReg=1, RegDst=0, Retire → FETCH.
- MEMWR (5): MemWrite, IorD=1, Retire → FETCH.
- EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUCtl from Funct: 0x20→2, 0x22→6, 0x24→0, 0x25→1, 0x2A→7 → ALUWB.
- ALUWB (7): RegWrite, RegDst=1, MemtoReg=0, Retire → FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUCtl=6, PCWriteCond, PCSource=01, Retire → FETCH.
- ADDIEX (9): ALUSrcA=1, ALUSrcB=10, ALUCtl=2 → ADDIWB.
- ADDIWB (10): RegWrite, RegDst=0, MemtoReg=0, Retire → FETCH.
- JUMP (11): PCWrite, PCSource=10, Retire → FETCH.
- Unused encodings 12–14 → FETCH, all outputs 0.

## Timing
- Reset asserted, at any time including mid-instruction: State=INIT immediately, with no clock needed. All outputs are 0 while reset is held, including PCEn, MemWrite and RegWrite.
- First rising edge after reset deasserts: INIT→FETCH. The first fetch occurs one cycle after release.
- Cycles per instruction, FETCH through retire inclusive:
  - lw 5
  - sw 4, R-type 4, addi 4
  - beq 3, j 3
  - illegal 2, with no Retire.
- Retire never coincides with FETCH. Exactly one Retire pulse per legal instruction.
- beq taken/not-taken is decided by Zero in the BRANCH cycle only. Zero in any other state does not affect PCEn.
- ALUCtl is valid for the whole state. The ALU result is captured at the end of that state.

## Structure
- Package mips_pkg holds:
  - opcode and Funct constants
  - ALUCtl encodings (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7)
  - the 4-bit state enum
  - ALUSrcB and PCSource select constants.
- One sub-module: alu_control. It maps a 2-bit ALUOp (00 add, 01 sub, 10 use Funct) plus Funct to ALUCtl, and flags an illegal Funct. The FSM drives ALUOp per state.

## Test plan
- Reset asserted mid-MEMRD, async between edges → State=0xF and all outputs 0 before the next edge. After release: FETCH, then DECODE.
- add instruction (Op=0x00, Funct=0x20) → states 0,1,6,7. ALUCtl=2 in EXEC; RegWrite=1, RegDst=1 in ALUWB; Retire once.
- slt, then or, then and (Funct 0x2A, 0x25, 0x24) → EXEC ALUCtl=7, 1, 0 respectively.
- lw (Op=0x23) → states 0,1,2,3,4. IorD=1 and MemRead in MEMRD; MemtoReg=1 and RegWrite in MEMWB. sw (0x2B) → 0,1,2,5 with MemWrite=1.
- beq (Op=0x04) with Zero=1 in BRANCH → PCEn=1, PCSource=01, ALUCtl=6. Same with Zero=0 → PCEn=0. Zero=1 forced during DECODE → PCEn stays 0.
- Op=0x3F, and separately Op=0x00 with Funct=0x07 → Illegal=1 in DECODE, next state FETCH, no RegWrite, no MemWrite, no Retire.

Source files
------------

// File: rtl/mips_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, Funct codes,
// ALU controls, datapath select values and the controller state enum.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  // ALUOP_NONE marks states that leave the ALU idle, so ALUCtl reads 0 there.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_INIT   = 4'd15
  } state_t;

endpackage

// File: rtl/mips_control_fsm_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface mips_control_fsm_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic [3:0] ALUCtl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       Retire;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Op, Funct, Zero,
    output ALUCtl, ALUSrcA, ALUSrcB, PCSource, PCEn, IorD, MemRead, MemWrite,
           IRWrite, RegWrite, RegDst, MemtoReg, Retire, Illegal, State
  );

  modport slave (
    output Op, Funct, Zero,
    input  ALUCtl, ALUSrcA, ALUSrcB, PCSource, PCEn, IorD, MemRead, MemWrite,
           IRWrite, RegWrite, RegDst, MemtoReg, Retire, Illegal, State
  );
endinterface

// File: rtl/mips_control_fsm_alu_control.sv
// Maps ALUOp (+ Funct for R-type) to the 4-bit ALU control; flags unsupported Funct
// independently of ALUOp so DECODE can use it for the legality check.
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctl,
  output logic       funct_bad
);

  logic [3:0] fn_ctl;

  always_comb begin
    fn_ctl    = ALU_AND;
    funct_bad = 1'b0;
    case (funct)
      FN_ADD:  fn_ctl = ALU_ADD;
      FN_SUB:  fn_ctl = ALU_SUB;
      FN_AND:  fn_ctl = ALU_AND;
      FN_OR:   fn_ctl = ALU_OR;
      FN_SLT:  fn_ctl = ALU_SLT;
      default: funct_bad = 1'b1;
    endcase
  end

  always_comb begin
    alu_ctl = ALU_AND;
    case (alu_op)
      ALUOP_ADD:   alu_ctl = ALU_ADD;
      ALUOP_SUB:   alu_ctl = ALU_SUB;
      ALUOP_FUNCT: alu_ctl = fn_ctl;
      default:     alu_ctl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS controller: Moore outputs from the state register, except PCEn (live Zero)
// and Illegal (live Op/Funct in DECODE). Async reset parks the machine in INIT with all outputs low.
module mips_control_fsm
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  mips_control_fsm_if.master   bus
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic [3:0] alu_ctl;
  logic       funct_bad;
  logic       pc_write, pc_write_cond;
  logic       alu_src_a, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, retire, illegal;
  logic [1:0] alu_src_b, pc_source;

  alu_control u_alu_control (
    .alu_op    (alu_op),
    .funct     (bus.Funct),
    .alu_ctl   (alu_ctl),
    .funct_bad (funct_bad)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    alu_op        = ALUOP_NONE;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    retire        = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only needs the compare.
        alu_src_b = SRCB_IMM_SH2;
        alu_op    = ALUOP_ADD;
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            illegal = funct_bad;
            state_d = funct_bad ? S_FETCH : S_EXEC;
          end
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        state_d   = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        retire        = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        retire    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.ALUCtl   = alu_ctl;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.PCSource = pc_source;
  assign bus.PCEn     = pc_write | (pc_write_cond & bus.Zero);
  assign bus.IorD     = iord;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.IRWrite  = ir_write;
  assign bus.RegWrite = reg_write;
  assign bus.RegDst   = reg_dst;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.Retire   = retire;
  assign bus.Illegal  = illegal;
  assign bus.State    = state_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench: expected per-cycle output vectors are queued with each instruction and
// compared cycle by cycle against the controller outputs.
module tb_mips_control_fsm;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  mips_control_fsm_if bus ();

  mips_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {State, ALUCtl, ALUSrcA, ALUSrcB, PCSource, PCEn, IorD, MemRead, MemWrite,
  //  IRWrite, RegWrite, RegDst, MemtoReg, Retire, Illegal}
  logic [22:0] obs;
  assign obs = {bus.State, bus.ALUCtl, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.PCEn,
                bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.RegDst, bus.MemtoReg, bus.Retire, bus.Illegal};

  typedef struct {
    string       tag;
    logic        zin;
    logic [22:0] v;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [22:0] ev(input logic [3:0] st, input logic [3:0] alu,
                                     input logic sa, input logic [1:0] sb, input logic [1:0] ps,
                                     input logic pcen, input logic iord, input logic mr,
                                     input logic mw, input logic irw, input logic rw,
                                     input logic rd, input logic m2r, input logic ret,
                                     input logic ill);
    return {st, alu, sa, sb, ps, pcen, iord, mr, mw, irw, rw, rd, m2r, ret, ill};
  endfunction

  function automatic logic [22:0] e_init();       return ev(4'hF, 4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic logic [22:0] e_fetch();      return ev(4'd0, 4'd2, 0, 2'd1, 2'd0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0); endfunction
  function automatic logic [22:0] e_decode(input logic ill);
                                                  return ev(4'd1, 4'd2, 0, 2'd3, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ill); endfunction
  function automatic logic [22:0] e_memadr();     return ev(4'd2, 4'd2, 1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic logic [22:0] e_memrd();      return ev(4'd3, 4'd0, 0, 2'd0, 2'd0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic logic [22:0] e_memwb();      return ev(4'd4, 4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0); endfunction
  function automatic logic [22:0] e_memwr();      return ev(4'd5, 4'd0, 0, 2'd0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0); endfunction
  function automatic logic [22:0] e_exec(input logic [3:0] a);
                                                  return ev(4'd6, a,    1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic logic [22:0] e_aluwb();      return ev(4'd7, 4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0); endfunction
  function automatic logic [22:0] e_branch(input logic z);
                                                  return ev(4'd8, 4'd6, 1, 2'd0, 2'd1, z, 0, 0, 0, 0, 0, 0, 0, 1, 0); endfunction
  function automatic logic [22:0] e_addiex();     return ev(4'd9, 4'd2, 1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic logic [22:0] e_addiwb();     return ev(4'd10, 4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0); endfunction
  function automatic logic [22:0] e_jump();       return ev(4'd11, 4'd0, 0, 2'd0, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0); endfunction

  task automatic push(input string tag, input logic zin, input logic [22:0] v);
    exp_t e;
    e.tag = tag;
    e.zin = zin;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic chk_now();
    exp_t e;
    e = exp_q.pop_front();
    bus.Zero = e.zin;
    #1;
    checks++;
    assert (obs === e.v)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      chk_now();
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  logic [5:0] fn_tab [4];
  logic [3:0] ctl_tab[4];

  initial begin
    fn_tab[0] = FN_SLT; ctl_tab[0] = 4'd7;
    fn_tab[1] = FN_OR;  ctl_tab[1] = 4'd1;
    fn_tab[2] = FN_AND; ctl_tab[2] = 4'd0;
    fn_tab[3] = FN_SUB; ctl_tab[3] = 4'd6;

    reset = 1'b1;
    bus.Op = OP_RTYPE;
    bus.Funct = FN_ADD;
    bus.Zero = 1'b0;
    repeat (2) @(negedge clk);
    push("reset_hold", 0, e_init());
    chk_now();
    reset = 1'b0;

    // add, checked from INIT through retire
    push("add_init", 0, e_init());
    push("add_fetch", 0, e_fetch());
    push("add_decode", 0, e_decode(0));
    push("add_exec", 0, e_exec(4'd2));
    push("add_aluwb", 0, e_aluwb());
    drain();

    for (int i = 0; i < 4; i++) begin
      bus.Funct = fn_tab[i];
      push("rtype_fetch", 0, e_fetch());
      push("rtype_decode", 0, e_decode(0));
      push($sformatf("rtype_exec_fn%h", fn_tab[i]), 1, e_exec(ctl_tab[i]));
      push("rtype_aluwb", 1, e_aluwb());
      drain();
    end

    bus.Op = OP_LW;
    push("lw_fetch", 0, e_fetch());
    push("lw_decode", 0, e_decode(0));
    push("lw_memadr", 0, e_memadr());
    push("lw_memrd", 0, e_memrd());
    push("lw_memwb", 0, e_memwb());
    drain();

    bus.Op = OP_SW;
    push("sw_fetch", 0, e_fetch());
    push("sw_decode", 0, e_decode(0));
    push("sw_memadr", 0, e_memadr());
    push("sw_memwr", 0, e_memwr());
    drain();

    bus.Op = OP_ADDI;
    push("addi_fetch", 0, e_fetch());
    push("addi_decode", 0, e_decode(0));
    push("addi_ex", 0, e_addiex());
    push("addi_wb", 0, e_addiwb());
    drain();

    bus.Op = OP_J;
    push("j_fetch", 0, e_fetch());
    push("j_decode", 0, e_decode(0));
    push("j_jump", 0, e_jump());
    drain();

    bus.Op = OP_BEQ;
    push("beq_t_fetch", 0, e_fetch());
    push("beq_t_decode", 0, e_decode(0));
    push("beq_taken", 1, e_branch(1));
    push("beq_nt_fetch", 0, e_fetch());
    push("beq_nt_decode", 0, e_decode(0));
    push("beq_not_taken", 0, e_branch(0));
    push("beq_z_fetch", 1, e_fetch());
    push("beq_zero_in_decode", 1, e_decode(0));
    push("beq_z_branch", 0, e_branch(0));
    drain();

    bus.Op = 6'h3F;
    push("ill_op_fetch", 0, e_fetch());
    push("ill_op_decode", 0, e_decode(1));
    drain();
    bus.Op = OP_RTYPE;
    bus.Funct = 6'h07;
    push("ill_fn_fetch", 0, e_fetch());
    push("ill_fn_decode", 0, e_decode(1));
    push("ill_fn_next_fetch", 0, e_fetch());
    drain();

    // Skipped illegal instruction left us one cycle into a new fetch; finish it as add.
    bus.Funct = FN_ADD;
    push("post_ill_decode", 0, e_decode(0));
    push("post_ill_exec", 0, e_exec(4'd2));
    push("post_ill_aluwb", 0, e_aluwb());
    drain();

    // Asynchronous reset between edges while in MEMRD
    bus.Op = OP_LW;
    push("rst_lw_fetch", 0, e_fetch());
    push("rst_lw_decode", 0, e_decode(0));
    push("rst_lw_memadr", 0, e_memadr());
    drain();
    push("rst_lw_memrd", 0, e_memrd());
    chk_now();
    #2;
    reset = 1'b1;
    push("async_reset", 0, e_init());
    chk_now();
    @(negedge clk);
    push("reset_held_edge", 0, e_init());
    chk_now();
    reset = 1'b0;
    bus.Op = OP_RTYPE;
    push("release_init", 0, e_init());
    push("release_fetch", 0, e_fetch());
    push("release_decode", 0, e_decode(0));
    push("release_exec", 0, e_exec(4'd2));
    push("release_aluwb", 0, e_aluwb());
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
